// File: rtl/hex_keypad_pkg.sv
// Shared types and decode helpers for the scanned 4x4 hex keypad reader.
package hex_keypad_pkg;

  localparam int unsigned HEX_DIGITS = 8;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_t;

  // Keypad legend, row-major: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = 0 F E D
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = '0;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'h0;
      4'hD: code = 4'hF;
      4'hE: code = 4'hE;
      4'hF: code = 4'hD;
      default: code = '0;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

  // Lowest-index active-low row wins when several are pressed together
  function automatic logic [1:0] low_row(input logic [3:0] rs);
    logic [1:0] r;
    r = 2'd3;
    if (!rs[2]) r = 2'd2;
    if (!rs[1]) r = 2'd1;
    if (!rs[0]) r = 2'd0;
    return r;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up keypad row inputs.
module keypad_row_sync (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] ROW,
  output logic [3:0] RS
);

  logic [3:0] meta;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta <= '1;
      RS   <= '1;
    end else begin
      meta <= ROW;
      RS   <= meta;
    end
  end

endmodule

// File: rtl/hex_keypad_scan.sv
// Scanned 4x4 hex keypad reader: column scan, debounce, one code per press,
// and a 32-bit digit entry register feeding the seven-segment driver.
module hex_keypad_scan
  import hex_keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV_BITS  = 16,
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  ROW,
  input  logic        CLR,
  output logic [3:0]  COL,
  output logic        KEY_VALID,
  output logic [3:0]  KEY_CODE,
  output logic [31:0] HEX
);

  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_TICKS);

  logic [3:0]               rs;
  logic [SCAN_DIV_BITS-1:0] div_cnt;
  logic                     tick;
  state_t                   state;
  logic [1:0]               col_idx;
  logic [1:0]               row_idx;
  logic [3:0]               deb_cnt;
  logic [3:0]               deb_next;
  logic [3:0]               code;

  keypad_row_sync u_row_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .ROW   (ROW),
    .RS    (rs)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick     = &div_cnt;
  assign deb_next = deb_cnt + 4'd1;
  assign code     = key_map(row_idx, col_idx);

  // COL is reloaded alongside col_idx so the pin comes straight from a flop
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_SCAN;
      col_idx   <= '0;
      row_idx   <= '0;
      deb_cnt   <= '0;
      COL       <= col_drive(2'd0);
      KEY_VALID <= 1'b0;
      KEY_CODE  <= '0;
      HEX       <= '0;
    end else begin
      KEY_VALID <= 1'b0;
      if (CLR) HEX <= '0;
      case (state)
        ST_SCAN: begin
          if (tick) begin
            if (rs != 4'hF) begin
              row_idx <= low_row(rs);
              deb_cnt <= '0;
              state   <= ST_DEBOUNCE;
            end else begin
              col_idx <= col_idx + 2'd1;
              COL     <= col_drive(col_idx + 2'd1);
            end
          end
        end
        ST_DEBOUNCE: begin
          if (tick) begin
            if (!rs[row_idx]) begin
              deb_cnt <= deb_next;
              if (deb_next == DEB_LAST) state <= ST_PRESSED;
            end else begin
              deb_cnt <= '0;
              state   <= ST_SCAN;
            end
          end
        end
        ST_PRESSED: begin
          KEY_VALID <= 1'b1;
          KEY_CODE  <= code;
          // A clear coinciding with a press keeps only the new digit
          if (CLR) HEX <= {{(4*HEX_DIGITS-4){1'b0}}, code};
          else     HEX <= {HEX[4*HEX_DIGITS-5:0], code};
          deb_cnt   <= '0;
          state     <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (tick) begin
            if (&rs) begin
              if (deb_next == DEB_LAST) begin
                deb_cnt <= '0;
                col_idx <= col_idx + 2'd1;
                COL     <= col_drive(col_idx + 2'd1);
                state   <= ST_SCAN;
              end else begin
                deb_cnt <= deb_next;
              end
            end else begin
              deb_cnt <= '0;
            end
          end
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_keypad_scan.sv
// Self-checking bench for hex_keypad_scan: key tables plus a scoreboard of
// expected {code, HEX} popped on every KEY_VALID pulse.
module tb_hex_keypad_scan;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  ROW;
  logic        CLR;
  logic [3:0]  COL;
  logic        KEY_VALID;
  logic [3:0]  KEY_CODE;
  logic [31:0] HEX;

  always #5 CLK = ~CLK;

  hex_keypad_scan #(
    .SCAN_DIV_BITS  (2),
    .DEBOUNCE_TICKS (4)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .ROW       (ROW),
    .CLR       (CLR),
    .COL       (COL),
    .KEY_VALID (KEY_VALID),
    .KEY_CODE  (KEY_CODE),
    .HEX       (HEX)
  );

  typedef struct {
    logic [3:0]  code;
    logic [31:0] hex;
  } exp_t;

  typedef struct {
    logic [3:0] rows;
    logic [1:0] col;
    logic [3:0] code;
  } vec_t;

  exp_t        sb[$];
  vec_t        keys[9];
  logic [3:0]  col_pat[4];
  logic [31:0] hex_m;
  int          errors = 0;
  int          checks = 0;
  int          pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (RST_N === 1'b1 && KEY_VALID === 1'b1) begin
      pulses++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_key_valid: KEY_CODE=0x%0h HEX=0x%0h with no press pending",
                 KEY_CODE, HEX);
      end else begin
        e = sb.pop_front();
        check("key_code", {28'h0, KEY_CODE}, {28'h0, e.code});
        check("hex_on_pulse", HEX, e.hex);
      end
    end
  end

  task automatic wait_col(input logic [1:0] col);
    int n;
    n = 0;
    while (COL === col_pat[col] && n < 64) begin
      @(negedge CLK);
      n++;
    end
    n = 0;
    while (COL !== col_pat[col] && n < 64) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 64) check("col_wait", {28'h0, COL}, {28'h0, col_pat[col]});
  endtask

  // Drive rows as soon as the wanted column appears, so the next tick latches it
  task automatic press(input logic [3:0] rows, input logic [1:0] col, input logic [3:0] code,
                       input bit expect_pulse, input int hold, input int gap, input bit with_clr);
    int p0;
    wait_col(col);
    p0 = pulses;
    if (expect_pulse) begin
      hex_m = with_clr ? {28'h0, code} : {hex_m[27:0], code};
      sb.push_back('{code, hex_m});
    end
    ROW = rows;
    if (with_clr) CLR = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      if (KEY_VALID === 1'b1) CLR = 1'b0;
    end
    CLR = 1'b0;
    ROW = 4'hF;
    repeat (gap) @(negedge CLK);
    check("pulse_count", pulses - p0, expect_pulse ? 1 : 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin : stim
    int n;
    int p0;
    col_pat[0] = 4'b1110;
    col_pat[1] = 4'b1101;
    col_pat[2] = 4'b1011;
    col_pat[3] = 4'b0111;
    keys[0] = '{4'b1110, 2'd0, 4'h1};
    keys[1] = '{4'b1110, 2'd1, 4'h2};
    keys[2] = '{4'b1110, 2'd2, 4'h3};
    keys[3] = '{4'b1101, 2'd0, 4'h4};
    keys[4] = '{4'b1101, 2'd1, 4'h5};
    keys[5] = '{4'b1101, 2'd2, 4'h6};
    keys[6] = '{4'b1011, 2'd0, 4'h7};
    keys[7] = '{4'b1011, 2'd1, 4'h8};
    keys[8] = '{4'b1011, 2'd2, 4'h9};
    hex_m = '0;

    RST_N = 1'b0;
    ROW   = 4'hF;
    CLR   = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_col", {28'h0, COL}, 32'hE);
    check("reset_key_valid", {31'h0, KEY_VALID}, 32'h0);
    check("reset_key_code", {28'h0, KEY_CODE}, 32'h0);
    check("reset_hex", HEX, 32'h0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Single press: key 6, then scanning must resume on col3
    press(4'b1101, 2'd2, 4'h6, 1'b1, 40, 0, 1'b0);
    check("single_key_code", {28'h0, KEY_CODE}, 32'h6);
    check("single_hex", HEX, 32'h0000_0006);
    n = 0;
    while (COL === col_pat[2] && n < 64) begin
      @(negedge CLK);
      n++;
    end
    check("resume_col", {28'h0, COL}, {28'h0, col_pat[3]});
    repeat (8) @(negedge CLK);

    // Reset mid-DEBOUNCE: no pulse, everything back to reset values
    wait_col(2'd0);
    ROW = 4'b1110;
    repeat (10) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("midrst_col", {28'h0, COL}, 32'hE);
    check("midrst_hex", HEX, 32'h0);
    check("midrst_key_code", {28'h0, KEY_CODE}, 32'h0);
    check("midrst_key_valid", {31'h0, KEY_VALID}, 32'h0);
    hex_m = '0;
    ROW = 4'hF;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge CLK);
      #1;
      check("col_step", {28'h0, COL}, {28'h0, col_pat[(k / 4) % 4]});
    end

    // Bounce shorter than the debounce window is ignored
    press(4'b1110, 2'd0, 4'h1, 1'b0, 8, 40, 1'b0);
    check("bounce_hex", HEX, 32'h0);
    begin
      logic [3:0] c0;
      c0 = COL;
      n = 0;
      while (COL === c0 && n < 8) begin
        @(negedge CLK);
        n++;
      end
      check("bounce_scan_resumed", {31'h0, (COL !== c0)}, 32'h1);
    end

    // Nine digits: oldest drops out of the 8-digit register
    p0 = pulses;
    for (int i = 0; i < 9; i++)
      press(keys[i].rows, keys[i].col, keys[i].code, 1'b1, 40, 24, 1'b0);
    check("entry_hex", HEX, 32'h2345_6789);
    check("entry_pulses", pulses - p0, 9);

    // Rows 0 and 2 together on col0: row0 wins, long hold gives no repeat
    press(4'b1010, 2'd0, 4'h1, 1'b1, 200, 40, 1'b0);
    check("multirow_hex", HEX, 32'h3456_7891);

    // Clear coinciding with a press keeps only the new digit
    for (int i = 0; i < 8; i++)
      press(keys[i].rows, keys[i].col, keys[i].code, 1'b1, 40, 24, 1'b0);
    check("preclear_hex", HEX, 32'h1234_5678);
    press(4'b1110, 2'd3, 4'hA, 1'b1, 40, 24, 1'b1);
    check("clr_press_hex", HEX, 32'h0000_000A);
    check("clr_press_code", {28'h0, KEY_CODE}, 32'hA);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    @(negedge CLK);
    hex_m = '0;
    check("clr_alone_hex", HEX, hex_m);
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hex_keypad_scan.md
# hex_keypad_scan

Scanned 4x4 hex keypad reader: the input-side counterpart of the multiplexed seven-segment display driver. Drives one active-low column at a time, samples the active-low rows, debounces, and reports one 4-bit key code per physical press. Accepted codes shift into a 32-bit entry register whose output connects directly to the display driver's 32-bit `HEX` input.

## Interface
Parameters:
- `SCAN_DIV_BITS`, default 16: scan tick every 2^SCAN_DIV_BITS clocks. Simulation uses 2.
- `DEBOUNCE_TICKS`, default 4: consecutive stable ticks required to accept a press or a release. Range 1–15.

Ports:
- `CLK`  in  1  system clock.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `ROW`  in  4  keypad rows, active-low, externally pulled up; asynchronous to `CLK`.
- `CLR`  in  1  synchronous clear of `HEX`, level, active-high.
- `COL`  out  4  column drive, active-low one-hot.
- `KEY_VALID`  out  1  one-cycle pulse per accepted press.
- `KEY_CODE`  out  4  last accepted code; held between presses.
- `HEX`  out  32  entry register; newest digit in [3:0].

## Operation
Rows and ticks:
- `ROW` passes through a 2-FF synchronizer; all decisions use the synchronized value `rs`.
- Tick counter: SCAN_DIV_BITS wide, free-running, wraps. `tick` is asserted when the counter is all-ones.
- Pressed row `r` is the lowest index with `rs[r]==0`. Column index `c`, 2 bits, wraps 3→0.

Key map (row r / col 0..3):
- r0: 1 2 3 A
- r1: 4 5 6 B
- r2: 7 8 9 C
- r3: 0 F E D

State machine (states SCAN, DEBOUNCE, PRESSED, RELEASE):
- SCAN, on tick:
  - Any `rs` bit low: latch `r` and `c`, clear the counter, go to DEBOUNCE. `c` is held.
  - No row low: `c <= c+1`.
- DEBOUNCE, on tick:
  - Latched row still low: counter +1. When the counter reaches DEBOUNCE_TICKS, go to PRESSED.
  - Latched row high: clear the counter, go to SCAN. `c` is unchanged, so the same column is rescanned.
- PRESSED (exactly one cycle):
  - `KEY_VALID=1`; `KEY_CODE <= map(r,c)`; `HEX <= {HEX[27:0], code}`.
  - Clear the counter, go to RELEASE.
- RELEASE, on tick:
  - All `rs` high: counter +1. When the counter reaches DEBOUNCE_TICKS, go to SCAN and set `c <= c+1`.
  - Any `rs` low: clear the counter.
  - A held key never repeats. Other keys pressed during RELEASE are ignored.

Outputs:
- `COL = ~(4'b0001 << c)`, decoded from the state register (glitch-free).
- `CLR`:
  - `CLR=1` alone: `HEX <= 0`.
  - `CLR=1` in the PRESSED cycle: `HEX <= {28'h0, code}`. `KEY_VALID` still pulses.
- `HEX` is a plain shift register: the 9th digit drops the oldest.

## Timing
- Reset values: `COL=4'b1110`, `KEY_VALID=0`, `KEY_CODE=0`, `HEX=0`, state SCAN, `c=0`, all counters 0.
- Reset asserted mid-operation returns to reset values immediately. No `KEY_VALID` is issued for a press in progress.
- Press latency:
  - `ROW` edge to `rs`: 2 cycles.
  - Detection at the next tick on which `c` selects that column.
  - DEBOUNCE_TICKS further ticks.
  - `KEY_VALID` 1 cycle after the final tick.
- Minimum accepted press: (DEBOUNCE_TICKS+1)·2^SCAN_DIV_BITS clocks.
- Minimum gap between two `KEY_VALID` pulses: (2·DEBOUNCE_TICKS+1) ticks.
- `KEY_CODE` and `HEX` update on the same edge on which `KEY_VALID` rises.

## Structure
- Package `hex_keypad_pkg`:
  - state enum
  - key-map constant or function
  - column one-hot decode function
  - `HEX_DIGITS=8`
- Sub-module `keypad_row_sync`: 4-bit 2-FF synchronizer with async active-low reset to 4'b1111.
- Tick divider and FSM stay in the top module.

## Test plan
(`SCAN_DIV_BITS=2`, `DEBOUNCE_TICKS=4`)
- **Reset:** assert `RST_N` low mid-DEBOUNCE → `COL=1110`, `HEX=0`, `KEY_CODE=0`, no `KEY_VALID`. After release, `COL` steps 1110→1101→1011→0111→1110 every 4 clocks.
- **Single press:** row1 low while col2 is driven, held 40 clocks → exactly one `KEY_VALID`, `KEY_CODE=6`, `HEX=0x00000006`. Release for 24 clocks → scanning resumes at col3.
- **Bounce:** row0 low for 2 ticks then high → no `KEY_VALID`, state returns to SCAN, `HEX` unchanged.
- **Entry and overflow:** enter keys 1,2,…,9 in sequence → `HEX=0x23456789`, nine `KEY_VALID` pulses.
- **Multi-row:** rows 0 and 2 low on col0 → code 1 (row0 wins). Key held 200 clocks → no repeat pulse.
- **Clear:** `CLR` held high through the PRESSED cycle of key 'A', starting from `HEX=0x12345678` → `HEX=0x0000000A`, `KEY_VALID` pulses. `CLR` alone later → `HEX=0`.
